// File: rtl/gpu_mem_pkg.sv
// Shared types and defaults for shared-memory initiators.
package gpu_mem_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_MEM_SIZE   = 32;
  localparam int OP_CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/shared_mem_lsu.sv
// Per-thread load/store unit driving one shared-memory port; one request in flight,
// absorbs the memory's one-cycle registered read latency.
module shared_mem_lsu
  import gpu_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEM_SIZE   = DEF_MEM_SIZE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [OP_CNT_W-1:0]   op_count,
  output logic [1:0]            state_dbg
);

  localparam logic [ADDR_WIDTH:0] MEM_LIM = (ADDR_WIDTH+1)'(MEM_SIZE);

  lsu_state_t state;
  logic       wr_q;
  logic       addr_err;

  assign addr_err = ({1'b0, req_addr} >= MEM_LIM);

  // Everything below is a decode of flops, so strobes cannot glitch.
  assign req_ready    = (state == IDLE);
  assign rsp_valid    = (state == RESP);
  assign mem_read_en  = (state == ISSUE) && !wr_q;
  assign mem_write_en = (state == ISSUE) &&  wr_q;
  assign state_dbg    = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      wr_q           <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      rsp_rdata      <= '0;
      rsp_error      <= 1'b0;
      op_count       <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wr_q           <= req_write;
          mem_addr       <= req_addr;
          mem_write_data <= req_wdata;
          rsp_rdata      <= '0;
          rsp_error      <= addr_err;
          state          <= addr_err ? RESP : ISSUE;
        end
        ISSUE: state <= wr_q ? RESP : WAIT;
        WAIT: begin
          rsp_rdata <= mem_read_data;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          state <= IDLE;
          if (op_count != '1) op_count <= op_count + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shared_mem_lsu.md
# shared_mem_lsu

Per-thread load/store unit acting as the initiator on one port of the multi-port shared memory. It accepts a single load or store from a thread pipeline over a valid/ready handshake and drives that port's read/write strobe, address and data. For loads it absorbs the memory's one-cycle registered read latency, then returns the result over a valid/ready response channel. One instance sits between each thread and its shared-memory port index.

## Interface
- DATA_WIDTH, 8, memory word width
- ADDR_WIDTH, 5, memory address width
- MEM_SIZE, 32, number of valid words; addresses >= MEM_SIZE are errors
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  thread presents a request
- req_ready  out  1  LSU can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  store data
- rsp_valid  out  1  response available
- rsp_ready  in  1  thread consumes response
- rsp_rdata  out  DATA_WIDTH  load result; 0 for stores and errors
- rsp_error  out  1  address out of range; no memory access made
- mem_read_en  out  1  to the shared-memory port's read_en bit
- mem_write_en  out  1  to the shared-memory port's write_en bit
- mem_addr  out  ADDR_WIDTH  port address
- mem_write_data  out  DATA_WIDTH  port write data
- mem_read_data  in  DATA_WIDTH  port read data (registered in the memory)
- op_count  out  16  completed responses, saturating at 16'hFFFF
- state_dbg  out  2  current FSM state encoding

## Operation
- FSM states: IDLE=0, ISSUE=1, WAIT=2, RESP=3.
- IDLE: req_ready=1. On req_valid, latch write/addr/wdata. If addr >= MEM_SIZE: go to RESP with rsp_error=1, rsp_rdata=0. Otherwise go to ISSUE.
- ISSUE: for exactly one cycle, assert mem_read_en (load) or mem_write_en (store) with the latched mem_addr/mem_write_data. A load then goes to WAIT; a store goes to RESP with rsp_rdata=0 and rsp_error=0.
- WAIT: capture mem_read_data into rsp_rdata, then go to RESP.
- RESP: rsp_valid=1. Response outputs hold stable until rsp_ready. On rsp_ready, go to IDLE and increment op_count if it is below 16'hFFFF.
- Memory strobes are decoded from the state flop only (glitch-free). They are 0 in every state except ISSUE.
- mem_addr and mem_write_data hold their latched values outside ISSUE.
- A store is acknowledged once it is issued. The memory's write-conflict arbitration may still drop it; the LSU neither detects nor retries dropped writes.
- There is no request bypass: a new request is accepted only in IDLE, i.e. no earlier than the cycle after the RESP handshake.

## Timing
- Reset (async assert): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, mem_read_en=0, mem_write_en=0, mem_addr=0, mem_write_data=0, op_count=0, state_dbg=0. Strobes drop immediately on reset_n low.
- Reset mid-operation: an in-flight request is abandoned and no response is produced. A strobe already sampled by the memory is not undone.
- Load latency: accept at edge E0. mem_read_en is high in cycle E0–E1. Data is captured at E2. rsp_valid is high from E2. Minimum load-to-load spacing is 4 cycles.
- Store latency: accept at E0. mem_write_en is high in cycle E0–E1. rsp_valid is high from E1.
- Error latency: accept at E0, rsp_valid is high from E0, no strobe is driven.
- rsp_ready held high: the response lasts exactly one cycle.

## Structure
- Shared package gpu_mem_pkg holds:
  - lsu_state_t enum (IDLE, ISSUE, WAIT, RESP, 2 bits)
  - default DATA_WIDTH/ADDR_WIDTH/MEM_SIZE constants
  - op-count width constant (16)
- Single module; no sub-module. The FSM, request latch and counter are small enough to keep flat.

## Test plan
- Memory preloaded with [0..7]=1..8. Load addr 5 -> mem_read_en for one cycle with mem_addr=5; rsp_valid 3 edges after accept; rsp_rdata=6, rsp_error=0; op_count=1.
- Store 42 to addr 17, then load addr 17 -> one mem_write_en pulse with mem_write_data=42; store rsp_valid 2 edges after accept; load returns 42.
- Load addr 31, then addr 32 with ADDR_WIDTH=6 -> addr 31 is read normally; addr 32 gives rsp_error=1, rsp_rdata=0, no mem strobe at any point.
- Hold rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stay stable; req_ready=0; a new req_valid is not accepted until 1 cycle after the handshake.
- Pull reset_n low in WAIT -> all outputs return to reset values asynchronously; no response is emitted; the next load after release behaves normally.
- Four instances on ports 0–3 each load [i] and [i+4] and store the sum to [16+i] -> memory [16..19]=6,8,10,12.
